// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-stage stall vector for load-use hazards
// and multi-cycle EX operations, plus a registered flush/redirect pulse.
// Keeps a saturating count of the stalled cycles.
module pipe_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        ex_start,
    input  logic        flush_req,
    input  logic [31:0] flush_pc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        ex_done,
    output logic        busy,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MULTI = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Hold PC..EX/MEM while EX is busy; hold PC..ID/EX on a load-use hazard.
    localparam logic [5:0] STALL_MULTI = 6'b001111;
    localparam logic [5:0] STALL_ID    = 6'b000111;
    // The ex_start cycle is itself a stall cycle, so the counter starts one short.
    localparam logic [5:0] CNT_LOAD    = 6'(DIV_CYCLES - 1);

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        flush_q, flush_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic        ex_done_q, ex_done_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [5:0]  stall_c;

    // Next-state, counter, redirect latch and combinational stall vector.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        cnt_d     = cnt_q;
        flush_d   = 1'b0;
        new_pc_d  = new_pc_q;
        ex_done_d = 1'b0;
        stall_c   = 6'b000000;
        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d  = FLUSH;
                    flush_d  = 1'b1;
                    new_pc_d = flush_pc;
                end else if (ex_start) begin
                    stall_c = STALL_MULTI;
                    cnt_d   = CNT_LOAD;
                    state_d = MULTI;
                end else if (stallreq_id) begin
                    stall_c = STALL_ID;
                end
            end
            MULTI: begin
                if (flush_req) begin
                    // Abort: the result is discarded, so no ex_done follows.
                    cnt_d    = 6'd0;
                    flush_d  = 1'b1;
                    new_pc_d = flush_pc;
                    state_d  = FLUSH;
                end else if (cnt_q != 6'd0) begin
                    stall_c = STALL_MULTI;
                    cnt_d   = cnt_q - 6'd1;
                end else begin
                    ex_done_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            FLUSH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset dominates the outputs combinationally.
    always_comb begin
        stall = rst ? 6'b000000 : stall_c;
        busy  = !rst && (state_q != IDLE);
    end

    // Saturating stall-cycle counter; never wraps.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((stall != 6'b000000) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 6'd0;
            flush_q     <= 1'b0;
            new_pc_q    <= 32'h0;
            ex_done_q   <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            flush_q     <= flush_d;
            new_pc_q    <= new_pc_d;
            ex_done_q   <= ex_done_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign flush     = flush_q;
    assign new_pc    = new_pc_q;
    assign ex_done   = ex_done_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl. Inputs change 1ns after the rising
// edge; outputs are sampled on the falling edge.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id;
    logic        ex_start;
    logic        flush_req;
    logic [31:0] flush_pc;

    logic [5:0]  stall,  stall2;
    logic        flush,  flush2;
    logic [31:0] new_pc, new_pc2;
    logic        ex_done, ex_done2;
    logic        busy,   busy2;
    logic [15:0] stall_cnt, stall_cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.DIV_CYCLES(32)) u_dut (
        .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_start(ex_start),
        .flush_req(flush_req), .flush_pc(flush_pc), .stall(stall), .flush(flush),
        .new_pc(new_pc), .ex_done(ex_done), .busy(busy), .stall_cnt(stall_cnt)
    );

    // Minimum-length instance sharing the same stimulus.
    pipe_ctrl #(.DIV_CYCLES(2)) u_dut_min (
        .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_start(ex_start),
        .flush_req(flush_req), .flush_pc(flush_pc), .stall(stall2), .flush(flush2),
        .new_pc(new_pc2), .ex_done(ex_done2), .busy(busy2), .stall_cnt(stall_cnt2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stallreq_id = 1'b0;
        ex_start    = 1'b0;
        flush_req   = 1'b0;
        flush_pc    = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        ex_start    = 1'b1;
        stallreq_id = 1'b1;
        flush_req   = 1'b0;
        flush_pc    = 32'h0;
        tick();
        @(negedge clk);
        n_checks++;
        if (stall !== 6'b000000) begin
            n_fail++; $display("FAIL rst_stall: got %b want 000000", stall);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_busy: got %b want 0", busy);
        end
        tick();
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (flush !== 1'b0 || ex_done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_flags: flush=%b ex_done=%b busy=%b want 0 0 0", flush, ex_done, busy);
        end
        n_checks++;
        if (new_pc !== 32'h0 || stall_cnt !== 16'd0) begin
            n_fail++; $display("FAIL rst_regs: new_pc=%h stall_cnt=%0d want 0 0", new_pc, stall_cnt);
        end
        tick();
    endtask

    task automatic test_multi();
        int stalls, stalls2, done_cyc;
        logic done2;
        do_reset();
        ex_start = 1'b1;
        @(negedge clk);
        n_checks++;
        if (stall !== 6'b001111 || busy !== 1'b0) begin
            n_fail++; $display("FAIL multi_start: stall=%b busy=%b want 001111 0", stall, busy);
        end
        stalls   = (stall  == 6'b001111) ? 1 : 0;
        stalls2  = (stall2 == 6'b001111) ? 1 : 0;
        done2    = 1'b0;
        done_cyc = -1;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            tick();
            ex_start = 1'b0;
            @(negedge clk);
            if (stall == 6'b001111) stalls++;
            if (!done2 && stall2 == 6'b001111) stalls2++;
            if (ex_done2) done2 = 1'b1;
            if (ex_done) begin
                done_cyc = cyc;
                break;
            end
        end
        n_checks++;
        if (done_cyc !== 33) begin
            n_fail++; $display("FAIL multi_done_cycle: got %0d want 33", done_cyc);
        end
        n_checks++;
        if (stalls !== 32) begin
            n_fail++; $display("FAIL multi_stall_cycles: got %0d want 32", stalls);
        end
        n_checks++;
        if (!done2 || stalls2 !== 2) begin
            n_fail++; $display("FAIL min_div_stall_cycles: got %0d done=%b want 2 1", stalls2, done2);
        end
        n_checks++;
        if (busy !== 1'b0 || flush !== 1'b0 || stall_cnt !== 16'd32) begin
            n_fail++; $display("FAIL multi_end: busy=%b flush=%b stall_cnt=%0d want 0 0 32", busy, flush, stall_cnt);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (ex_done !== 1'b0 || busy !== 1'b0 || stall !== 6'b000000) begin
            n_fail++; $display("FAIL multi_after: ex_done=%b busy=%b stall=%b want 0 0 000000", ex_done, busy, stall);
        end
    endtask

    task automatic test_stallreq();
        do_reset();
        stallreq_id = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (stall !== 6'b000111 || busy !== 1'b0) begin
                n_fail++; $display("FAIL stallreq_%0d: stall=%b busy=%b want 000111 0", i, stall, busy);
            end
            tick();
        end
        stallreq_id = 1'b0;
        @(negedge clk);
        n_checks++;
        if (stall !== 6'b000000 || busy !== 1'b0 || stall_cnt !== 16'd3) begin
            n_fail++; $display("FAIL stallreq_end: stall=%b busy=%b stall_cnt=%0d want 000000 0 3", stall, busy, stall_cnt);
        end
        tick();
    endtask

    task automatic test_flush_idle();
        do_reset();
        flush_req = 1'b1;
        flush_pc  = 32'h0000_0100;
        @(negedge clk);
        n_checks++;
        if (stall !== 6'b000000 || flush !== 1'b0) begin
            n_fail++; $display("FAIL flush_req_cycle: stall=%b flush=%b want 000000 0", stall, flush);
        end
        tick();
        // Inputs during FLUSH must be ignored.
        flush_req   = 1'b0;
        flush_pc    = 32'hDEAD_BEEF;
        ex_start    = 1'b1;
        stallreq_id = 1'b1;
        @(negedge clk);
        n_checks++;
        if (flush !== 1'b1 || new_pc !== 32'h0000_0100 || busy !== 1'b1 || stall !== 6'b000000) begin
            n_fail++; $display("FAIL flush_cycle: flush=%b new_pc=%h busy=%b stall=%b want 1 00000100 1 000000", flush, new_pc, busy, stall);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if (flush !== 1'b0 || busy !== 1'b0 || ex_done !== 1'b0 || new_pc !== 32'h0000_0100) begin
            n_fail++; $display("FAIL flush_after: flush=%b busy=%b ex_done=%b new_pc=%h want 0 0 0 00000100", flush, busy, ex_done, new_pc);
        end
        tick();
    endtask

    task automatic test_flush_multi();
        logic bad_done, bad_stall, bad_flush;
        do_reset();
        ex_start = 1'b1;
        tick();
        ex_start = 1'b0;
        repeat (4) tick();
        flush_req = 1'b1;
        flush_pc  = 32'h2000_0040;
        tick();
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if (flush !== 1'b1 || new_pc !== 32'h2000_0040 || stall !== 6'b000000 || ex_done !== 1'b0) begin
            n_fail++; $display("FAIL abort_flush: flush=%b new_pc=%h stall=%b ex_done=%b want 1 20000040 000000 0", flush, new_pc, stall, ex_done);
        end
        bad_done = 1'b0; bad_stall = 1'b0; bad_flush = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            @(negedge clk);
            if (ex_done) bad_done = 1'b1;
            if (stall != 6'b000000) bad_stall = 1'b1;
            if (flush || busy) bad_flush = 1'b1;
        end
        n_checks++;
        if (bad_done !== 1'b0 || bad_stall !== 1'b0 || bad_flush !== 1'b0) begin
            n_fail++; $display("FAIL abort_after: ex_done_seen=%b stall_seen=%b busy_or_flush_seen=%b want 0 0 0", bad_done, bad_stall, bad_flush);
        end
    endtask

    task automatic test_flush_and_start();
        logic bad;
        do_reset();
        flush_req   = 1'b1;
        ex_start    = 1'b1;
        stallreq_id = 1'b1;
        flush_pc    = 32'h0000_0800;
        @(negedge clk);
        n_checks++;
        if (stall !== 6'b000000) begin
            n_fail++; $display("FAIL both_stall: got %b want 000000", stall);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if (flush !== 1'b1 || new_pc !== 32'h0000_0800 || busy !== 1'b1) begin
            n_fail++; $display("FAIL both_flush: flush=%b new_pc=%h busy=%b want 1 00000800 1", flush, new_pc, busy);
        end
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            @(negedge clk);
            if (busy || ex_done || flush || stall != 6'b000000) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0 || stall_cnt !== 16'd0) begin
            n_fail++; $display("FAIL both_no_multi: activity_seen=%b stall_cnt=%0d want 0 0", bad, stall_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic bad;
        do_reset();
        ex_start = 1'b1;
        tick();
        ex_start = 1'b0;
        // cnt is 31 after the start edge; 21 more edges bring it to 10.
        repeat (21) tick();
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (stall !== 6'b000000 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_during: stall=%b busy=%b want 000000 0", stall, busy);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ex_done !== 1'b0 || flush !== 1'b0 || new_pc !== 32'h0 || stall_cnt !== 16'd0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_after: ex_done=%b flush=%b new_pc=%h stall_cnt=%0d busy=%b want 0 0 0 0 0", ex_done, flush, new_pc, stall_cnt, busy);
        end
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            @(negedge clk);
            if (ex_done || flush || busy) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_no_done: activity_seen=%b want 0", bad);
        end
        // Reset landing on the FLUSH cycle.
        flush_req = 1'b1;
        flush_pc  = 32'h0000_0300;
        tick();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (flush !== 1'b0 || busy !== 1'b0 || new_pc !== 32'h0) begin
            n_fail++; $display("FAIL rst_in_flush: flush=%b busy=%b new_pc=%h want 0 0 0", flush, busy, new_pc);
        end
        tick();
    endtask

    task automatic test_saturate();
        do_reset();
        stallreq_id = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        n_checks++;
        if (stall_cnt !== 16'hFFFE) begin
            n_fail++; $display("FAIL sat_pre: got %h want fffe", stall_cnt);
        end
        tick();
        n_checks++;
        if (stall_cnt !== 16'hFFFF) begin
            n_fail++; $display("FAIL sat_reach: got %h want ffff", stall_cnt);
        end
        repeat (4465) @(posedge clk);
        #1;
        n_checks++;
        if (stall_cnt !== 16'hFFFF || stall !== 6'b000111 || busy !== 1'b0) begin
            n_fail++; $display("FAIL sat_hold: stall_cnt=%h stall=%b busy=%b want ffff 000111 0", stall_cnt, stall, busy);
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_multi();
        test_stallreq();
        test_flush_idle();
        test_flush_multi();
        test_flush_and_start();
        test_reset_mid();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter DIV_CYCLES, default 32, SHALL set the number of stall cycles for one multi-cycle EX operation; the legal range is 2..64.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit, SHALL be the synchronous, active-high reset.
REQ-004 Port stallreq_id, input, 1 bit, SHALL be the ID-stage stall request (load-use hazard), level-sensitive.
REQ-005 Port ex_start, input, 1 bit, SHALL be the EX-stage request that a multi-cycle operation entered EX this cycle.
REQ-006 Port flush_req, input, 1 bit, SHALL be the exception/redirect request, sampled every cycle.
REQ-007 Port flush_pc, input, 32 bits, SHALL be the redirect target, valid when flush_req=1.
REQ-008 Port stall, output, 6 bits, SHALL be the per-stage hold vector: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB.
REQ-009 Port flush, output, 1 bit, SHALL be a registered one-cycle pulse that clears all pipeline registers.
REQ-010 Port new_pc, output, 32 bits, SHALL be the registered redirect PC, meaningful when flush=1.
REQ-011 Port ex_done, output, 1 bit, SHALL be a registered one-cycle pulse marking multi-cycle result valid.
REQ-012 Port busy, output, 1 bit, SHALL be 1 whenever the state is not IDLE.
REQ-013 Port stall_cnt, output, 16 bits, SHALL be the saturating count of cycles with stall != 0.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, MULTI, FLUSH.
REQ-015 IDLE with flush_req=1 SHALL go to FLUSH next cycle, latching new_pc<=flush_pc and flush<=1; this takes priority over ex_start and stallreq_id.
REQ-016 IDLE with ex_start=1 and flush_req=0 SHALL drive stall=6'b001111 in that same cycle, load cnt<=DIV_CYCLES-1, and go to MULTI.
REQ-017 IDLE with only stallreq_id=1 SHALL drive stall=6'b000111 combinationally in that same cycle and SHALL remain in IDLE.
REQ-018 IDLE with no request SHALL drive stall=6'b000000.
REQ-019 MULTI with cnt!=0 SHALL drive stall=6'b001111 and decrement cnt by 1; stallreq_id and ex_start SHALL be ignored.
REQ-020 MULTI with cnt==0 SHALL drive stall=0, pulse ex_done=1 on the next edge, and return to IDLE.
REQ-021 The total stall=001111 cycles per operation, including the ex_start cycle, SHALL equal DIV_CYCLES exactly.
REQ-022 MULTI with flush_req=1 at any cnt SHALL abort the operation: no ex_done, cnt<=0, latch new_pc, go to FLUSH.
REQ-023 FLUSH SHALL last exactly one cycle: flush=1, stall=0; all inputs SHALL be ignored; the next state SHALL be IDLE with flush<=0.
REQ-024 flush and ex_done SHALL never be 1 in the same cycle.
REQ-025 new_pc SHALL hold its last value when no flush is taken.
REQ-026 stall_cnt SHALL increment by 1 each cycle stall!=0 and SHALL saturate at 16'hFFFF, with no wrap.
REQ-027 cnt SHALL be 6 bits wide; DIV_CYCLES-1 SHALL be truncated to 6 bits without error for the legal range.

Reset
REQ-028 With rst=1 at a clock edge: state<=IDLE, cnt<=0, flush<=0, new_pc<=32'h0, ex_done<=0, stall_cnt<=0.
REQ-029 While rst=1, stall SHALL be forced to 0 and busy to 0, regardless of inputs.
REQ-030 A reset asserted mid-MULTI or in FLUSH SHALL abandon the operation; no ex_done or flush pulse SHALL follow it.

Verification
REQ-031 DIV_CYCLES=32, single-cycle ex_start pulse -> stall=001111 for exactly 32 cycles, then ex_done=1 for 1 cycle, busy low afterward, stall_cnt=32.
REQ-032 stallreq_id high for 3 cycles in IDLE -> stall=000111 in the same 3 cycles, state stays IDLE, stall_cnt=3.
REQ-033 flush_req=1 with flush_pc=32'h0000_0100 in IDLE -> next cycle flush=1 and new_pc=32'h100; the following cycle flush=0 and state IDLE.
REQ-034 ex_start, then flush_req 5 cycles later -> FLUSH next cycle, no ex_done ever, stall=0 from the FLUSH cycle on.
REQ-035 flush_req and ex_start in the same IDLE cycle -> FLUSH taken, MULTI never entered, stall=0 that cycle.
REQ-036 rst pulsed at cnt=10 in MULTI; separately, stall forced high 70000 cycles -> all outputs at reset values, no ex_done; stall_cnt holds at 16'hFFFF.
